// File: rtl/ht_reset_seq_if.sv
// Handshake bundle between the reset sequencer and the units it initialises.
// The sequencer owns the master modport; the downstream units (or a bench) own the slave modport.
interface ht_reset_seq_if #(
    parameter int NUM_UNITS = 4
);
    logic                 i_rst_req;
    logic [NUM_UNITS-1:0] i_done;
    logic                 r_reset;
    logic                 r_ready;
    logic                 r_timeout;
    logic                 r_busy;

    modport master (
        input  i_rst_req,
        input  i_done,
        output r_reset,
        output r_ready,
        output r_timeout,
        output r_busy
    );

    modport slave (
        output i_rst_req,
        output i_done,
        input  r_reset,
        input  r_ready,
        input  r_timeout,
        input  r_busy
    );
endinterface

// File: rtl/ht_reset_seq.sv
// Unit reset sequencer: stretches reset to MIN_CYC cycles, then waits (with timeout)
// for every downstream unit to report init done before raising r_ready.
module ht_reset_seq #(
    parameter int MIN_CYC    = 8,
    parameter int NUM_UNITS  = 4,
    parameter int DONE_BLANK = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clk1x,
    input  logic          i_reset,
    ht_reset_seq_if.master bus
);

    localparam int CNT_SPAN = (MIN_CYC > TIMEOUT) ? MIN_CYC : TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_SPAN) + 1;

    typedef enum logic [1:0] {
        S_ASRT = 2'd0,
        S_WAIT = 2'd1,
        S_RDY  = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    // Single physical source for every downstream capture flop; keep it intact.
    (* keep = "true", dont_touch = "true", dont_retime = "true" *)
    logic               r_reset_q;
    logic               r_ready_q;
    logic               r_timeout_q;
    logic               r_busy_q;

    logic [NUM_UNITS-1:0] done_w;
    logic                 all_done;

    assign done_w   = bus.i_done;
    // Stale done levels from before the reset are masked for the first DONE_BLANK wait cycles.
    assign all_done = (cnt_q >= CNT_W'(DONE_BLANK)) && (&done_w);
    assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: i_reset is sampled inside the clocked block, so it is a synchronous reset with top priority.
    // NOTE: every state/output update below is non-blocking so all flops see pre-edge values.
    always_ff @(posedge clk1x) begin
        if (i_reset) begin
            state_q     <= S_ASRT;
            cnt_q       <= '0;
            r_reset_q   <= 1'b1;
            r_busy_q    <= 1'b1;
            r_ready_q   <= 1'b0;
            r_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_ASRT: begin
                    if (bus.i_rst_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(MIN_CYC - 1)) begin
                        state_q   <= S_WAIT;
                        cnt_q     <= '0;
                        r_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_WAIT: begin
                    if (bus.i_rst_req) begin
                        state_q     <= S_ASRT;
                        cnt_q       <= '0;
                        r_reset_q   <= 1'b1;
                        r_timeout_q <= 1'b0;
                    end else if (all_done) begin
                        state_q     <= S_RDY;
                        r_ready_q   <= 1'b1;
                        r_busy_q    <= 1'b0;
                        r_timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= S_RDY;
                        r_ready_q   <= 1'b1;
                        r_busy_q    <= 1'b0;
                        r_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RDY: begin
                    if (bus.i_rst_req) begin
                        state_q     <= S_ASRT;
                        cnt_q       <= '0;
                        r_reset_q   <= 1'b1;
                        r_ready_q   <= 1'b0;
                        r_busy_q    <= 1'b1;
                        r_timeout_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_ASRT;
                    cnt_q       <= '0;
                    r_reset_q   <= 1'b1;
                    r_busy_q    <= 1'b1;
                    r_ready_q   <= 1'b0;
                    r_timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r_reset   = r_reset_q;
    assign bus.r_ready   = r_ready_q;
    assign bus.r_timeout = r_timeout_q;
    assign bus.r_busy    = r_busy_q;

endmodule

// File: tb/tb_ht_reset_seq.sv
// Bench for ht_reset_seq: the driver predicts output edges (r_reset/r_ready changes) from
// the timing rules and queues them; a monitor pops and compares whenever an output changes.
`timescale 1ns/1ps
module tb_ht_reset_seq;

    localparam int MIN_CYC    = 8;
    localparam int NU         = 4;
    localparam int DONE_BLANK = 2;
    localparam int TIMEOUT    = 1024;
    localparam int NEVER      = 32'h7fff_ffff;

    typedef enum int {EV_RST_RISE, EV_RST_FALL, EV_RDY_RISE, EV_RDY_FALL} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       at;
        bit       tmo;
    } ev_t;
    typedef int arr_t [NU];

    logic clk = 1'b0;
    logic i_reset;

    ht_reset_seq_if #(.NUM_UNITS(NU)) bus ();

    ht_reset_seq #(
        .MIN_CYC   (MIN_CYC),
        .NUM_UNITS (NU),
        .DONE_BLANK(DONE_BLANK),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk1x  (clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  sb_q[$];
    int   anchor;
    int   cur_f;
    int   cur_rd;
    bit   started   = 1'b0;
    bit   exp_tmo   = 1'b0;
    bit   mon_en    = 1'b0;
    bit   mon_armed = 1'b0;
    logic prev_reset;
    logic prev_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void push(input ev_kind_e k, input int at, input bit tmo);
        ev_t ev;
        ev.kind = k;
        ev.at   = at;
        ev.tmo  = tmo;
        sb_q.push_back(ev);
    endfunction

    task automatic expect_ev(input ev_kind_e kind);
        ev_t ev;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at edge %0d expected none", kind, edge_n);
            return;
        end
        ev = sb_q.pop_front();
        check("event_kind", kind, ev.kind);
        check("event_edge", edge_n, ev.at);
        if (ev.kind == EV_RDY_RISE) exp_tmo = ev.tmo;
        else if (ev.kind == EV_RDY_FALL) exp_tmo = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!mon_armed) begin
                prev_reset = bus.r_reset;
                prev_ready = bus.r_ready;
                mon_armed  = 1'b1;
            end
            if (bus.r_reset !== prev_reset) expect_ev(bus.r_reset ? EV_RST_RISE : EV_RST_FALL);
            if (bus.r_ready !== prev_ready) expect_ev(bus.r_ready ? EV_RDY_RISE : EV_RDY_FALL);
            check("busy_vs_ready", bus.r_busy, !bus.r_ready);
            check("timeout_flag", bus.r_timeout, exp_tmo);
            prev_reset = bus.r_reset;
            prev_ready = bus.r_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Done pattern presented before edge e; cnt is the wait count that edge will see.
    function automatic logic [NU-1:0] done_for(input arr_t arr, input int cnt, input bit after_rdy);
        logic [NU-1:0] d;
        d = '0;
        if (cnt < DONE_BLANK || after_rdy) begin
            d = ($urandom_range(0, 1) == 1) ? '1 : NU'($urandom);
        end else begin
            for (int u = 0; u < NU; u++) d[u] = (cnt >= arr[u]);
        end
        return d;
    endfunction

    // Assert i_reset or i_rst_req for hold edges; the last such edge becomes the new anchor.
    task automatic restart(input bit use_rst, input int hold);
        int q;
        q = edge_n + 1;
        if (started) begin
            if (q > cur_f)  push(EV_RST_RISE, q, 1'b0);
            if (q > cur_rd) push(EV_RDY_FALL, q, 1'b0);
        end
        for (int h = 0; h < hold; h++) begin
            i_reset       = use_rst;
            bus.i_rst_req = !use_rst;
            bus.i_done    = NU'($urandom);
            tick();
        end
        i_reset       = 1'b0;
        bus.i_rst_req = 1'b0;
        anchor        = edge_n;
        started       = 1'b1;
    endtask

    // arr[u] = wait count from which unit u reports done. k = edge offset of the next
    // restart from the anchor: 0 = let it finish plus idle, -1 = random interrupt.
    task automatic phase(input arr_t arr, input int k);
        int f;
        int w;
        int rd;
        bit tmo;
        f = anchor + MIN_CYC;
        w = 0;
        foreach (arr[u]) if (arr[u] > w) w = arr[u];
        if (w < DONE_BLANK) w = DONE_BLANK;
        if (w <= TIMEOUT - 1) begin
            rd  = f + 1 + w;
            tmo = 1'b0;
        end else begin
            rd  = f + TIMEOUT;
            tmo = 1'b1;
        end
        if (k == 0)     k = rd - anchor + 1 + int'($urandom_range(1, 6));
        else if (k < 0) k = int'($urandom_range(1, rd - anchor));
        if (f < anchor + k)  push(EV_RST_FALL, f, 1'b0);
        if (rd < anchor + k) push(EV_RDY_RISE, rd, tmo);
        cur_f  = f;
        cur_rd = rd;
        for (int e = anchor + 1; e < anchor + k; e++) begin
            bus.i_done = done_for(arr, e - f - 1, e > rd);
            tick();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got edge %0d expected < 150000", edge_n);
        $fatal(1);
    end

    initial begin
        arr_t a;
        i_reset       = 1'b1;
        bus.i_rst_req = 1'b0;
        bus.i_done    = '1;

        restart(1'b1, 5);
        check("por_r_reset",   bus.r_reset,   1);
        check("por_r_ready",   bus.r_ready,   0);
        check("por_r_busy",    bus.r_busy,    1);
        check("por_r_timeout", bus.r_timeout, 0);
        mon_en = 1'b1;

        a = '{0, 0, 0, 0};
        phase(a, 0);

        restart(1'b0, 1);
        a = '{5, 9, 14, 20};
        phase(a, 0);

        restart(1'b0, 1);
        a = '{0, 0, 0, NEVER};
        phase(a, 0);

        restart(1'b0, 1);
        a = '{TIMEOUT - 1, 0, 3, 7};
        phase(a, 0);

        restart(1'b0, 1);
        a = '{10, 10, 10, 10};
        phase(a, 6);
        restart(1'b0, 1);
        phase(a, MIN_CYC + 4);
        restart(1'b0, 1);
        a = '{30, 2, 30, 5};
        phase(a, MIN_CYC + 10);
        restart(1'b1, 2);
        a = '{3, 0, 1, 4};
        phase(a, 0);
        restart(1'b1, 3);
        a = '{0, 6, 0, 0};
        phase(a, 0);

        for (int s = 0; s < 25; s++) begin
            restart($urandom_range(0, 3) == 0, int'($urandom_range(1, 3)));
            foreach (a[u]) a[u] = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 40));
            phase(a, ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        restart(1'b0, 1);
        a = '{1, 2, 3, 4};
        phase(a, 0);
        repeat (4) tick();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
